// File: rtl/r_type_mdu_pkg.sv
// Shared decode types for the R-type execute unit: op codes, funct7 groups,
// FSM states and the {funct7,funct3} decoder.
package r_type_mdu_pkg;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_ILLEGAL
  } rtype_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  function automatic rtype_op_e decode_op(input logic [6:0] f7, input logic [2:0] f3);
    rtype_op_e op;
    op = OP_ILLEGAL;
    case (f7)
      FUNCT7_BASE: begin
        case (f3)
          3'd0:    op = OP_ADD;
          3'd1:    op = OP_SLL;
          3'd2:    op = OP_SLT;
          3'd3:    op = OP_SLTU;
          3'd4:    op = OP_XOR;
          3'd5:    op = OP_SRL;
          3'd6:    op = OP_OR;
          default: op = OP_AND;
        endcase
      end
      FUNCT7_ALT: begin
        case (f3)
          3'd0:    op = OP_SUB;
          3'd5:    op = OP_SRA;
          default: op = OP_ILLEGAL;
        endcase
      end
      FUNCT7_MEXT: begin
        case (f3)
          3'd0:    op = OP_MUL;
          3'd1:    op = OP_MULH;
          3'd2:    op = OP_MULHSU;
          3'd3:    op = OP_MULHU;
          3'd4:    op = OP_DIV;
          3'd5:    op = OP_DIVU;
          3'd6:    op = OP_REM;
          default: op = OP_REMU;
        endcase
      end
      default: op = OP_ILLEGAL;
    endcase
    return op;
  endfunction

  function automatic logic op_is_mul(input rtype_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  function automatic logic op_is_div(input rtype_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/r_type_mdu_iter.sv
// Iterative multiply/divide datapath: one bit per cycle on operand magnitudes,
// sign fix-up applied to the final step so the result is ready with done.
module r_type_mdu_iter
  import r_type_mdu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  rtype_op_e       op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam logic [SHAMT_W:0] CNT_INIT = (SHAMT_W+1)'(XLEN-1);
  localparam logic [SHAMT_W:0] CNT_ONE  = (SHAMT_W+1)'(1);
  localparam logic [SHAMT_W:0] CNT_ZERO = (SHAMT_W+1)'(0);

  logic            r_active;
  logic [SHAMT_W:0] r_cnt;
  logic            r_is_div;
  rtype_op_e       r_op;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;

  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN:0]   w_add;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_hi_n;
  logic [XLEN-1:0] w_lo_n;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0] w_q;
  logic [XLEN-1:0] w_r;

  // MULHSU treats only rs1 as signed; the unsigned ops never negate.
  assign w_a_neg = a[XLEN-1] & ((op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                                (op == OP_DIV) || (op == OP_REM));
  assign w_b_neg = b[XLEN-1] & ((op == OP_MUL) || (op == OP_MULH) ||
                                (op == OP_DIV) || (op == OP_REM));
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  // One shift-add or restoring-subtract step and the sign-corrected result.
  always_comb begin
    w_add  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    w_ge   = ({r_hi, r_lo[XLEN-1]} >= {1'b0, r_b});
    w_diff = {r_hi[XLEN-2:0], r_lo[XLEN-1]} - r_b;
    if (r_is_div) begin
      w_hi_n = w_ge ? w_diff : {r_hi[XLEN-2:0], r_lo[XLEN-1]};
      w_lo_n = {r_lo[XLEN-2:0], w_ge};
    end else begin
      w_hi_n = w_add[XLEN:1];
      w_lo_n = {w_add[0], r_lo[XLEN-1:1]};
    end
    w_prod_s = r_neg_q ? -{w_hi_n, w_lo_n} : {w_hi_n, w_lo_n};
    w_q      = r_neg_q ? -w_lo_n : w_lo_n;
    w_r      = r_neg_r ? -w_hi_n : w_hi_n;
    case (r_op)
      OP_MUL:                        res = w_prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  res = w_prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               res = w_q;
      OP_REM, OP_REMU:               res = w_r;
      default:                       res = {XLEN{1'b0}};
    endcase
  end

  assign done = r_active && (r_cnt == CNT_ZERO);

  // Operand capture on start, then one iteration per cycle until the counter hits zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_cnt    <= CNT_ZERO;
      r_is_div <= 1'b0;
      r_op     <= OP_ADD;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= {XLEN{1'b0}};
      r_lo     <= {XLEN{1'b0}};
      r_b      <= {XLEN{1'b0}};
    end else if (start) begin
      r_active <= 1'b1;
      r_cnt    <= CNT_INIT;
      r_is_div <= op_is_div(op);
      r_op     <= op;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_hi     <= {XLEN{1'b0}};
      r_lo     <= op_is_div(op) ? w_a_mag : w_b_mag;
      r_b      <= op_is_div(op) ? w_b_mag : w_a_mag;
    end else if (r_active) begin
      r_hi     <= w_hi_n;
      r_lo     <= w_lo_n;
      r_cnt    <= r_cnt - CNT_ONE;
      r_active <= (r_cnt != CNT_ZERO);
    end else begin
      r_active <= 1'b0;
    end
  end

endmodule

// File: rtl/r_type_mdu.sv
// R-type execute unit: single-cycle base ALU, iterative M-extension ops,
// valid/ready handshake on both sides.
module r_type_mdu
  import r_type_mdu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic            busy
);

  localparam logic [XLEN-1:0] X_ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] X_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] X_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e      r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;
  logic [XLEN-1:0] r_result;
  logic            r_illegal;

  rtype_op_e       w_op;
  logic [SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0] w_alu;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  mdu_state_e      w_state_nxt;
  logic            w_start;
  logic [XLEN-1:0] w_res_nxt;
  logic            w_ill_nxt;
  logic            w_iter_done;
  logic [XLEN-1:0] w_iter_res;

  assign w_op    = decode_op(funct7, funct3);
  assign w_shamt = rs2[SHAMT_W-1:0];
  assign w_div0  = (rs2 == X_ZERO);
  assign w_ovf   = (rs1 == X_MIN) && (rs2 == X_ONES);

  // Base-op ALU, evaluated on the operands presented at accept.
  always_comb begin
    case (w_op)
      OP_ADD:  w_alu = rs1 + rs2;
      OP_SUB:  w_alu = rs1 - rs2;
      OP_SLL:  w_alu = rs1 << w_shamt;
      OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
      OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
      OP_XOR:  w_alu = rs1 ^ rs2;
      OP_SRL:  w_alu = rs1 >> w_shamt;
      OP_SRA:  w_alu = $signed(rs1) >>> w_shamt;
      OP_OR:   w_alu = rs1 | rs2;
      OP_AND:  w_alu = rs1 & rs2;
      default: w_alu = X_ZERO;
    endcase
  end

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  always_comb begin
    w_special = ((w_op == OP_DIVU) || (w_op == OP_REMU)) ? w_div0 :
                ((w_op == OP_DIV)  || (w_op == OP_REM))  ? (w_div0 || w_ovf) : 1'b0;
    case (w_op)
      OP_DIV:  w_special_res = w_div0 ? X_ONES : rs1;
      OP_DIVU: w_special_res = X_ONES;
      OP_REM:  w_special_res = w_div0 ? rs1 : X_ZERO;
      OP_REMU: w_special_res = rs1;
      default: w_special_res = X_ZERO;
    endcase
  end

  // Next-state, iterator start and next result/illegal values.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_res_nxt   = r_result;
    w_ill_nxt   = r_illegal;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_ill_nxt = 1'b0;
          if (w_op == OP_ILLEGAL) begin
            w_state_nxt = DONE;
            w_res_nxt   = X_ZERO;
            w_ill_nxt   = 1'b1;
          end else if (op_is_mul(w_op)) begin
            w_state_nxt = MUL;
            w_start     = 1'b1;
          end else if (op_is_div(w_op) && !w_special) begin
            w_state_nxt = DIV;
            w_start     = 1'b1;
          end else if (op_is_div(w_op)) begin
            w_state_nxt = DONE;
            w_res_nxt   = w_special_res;
          end else begin
            w_state_nxt = DONE;
            w_res_nxt   = w_alu;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      MUL, DIV: begin
        if (w_iter_done) begin
          w_state_nxt = DONE;
          w_res_nxt   = w_iter_res;
        end else begin
          w_state_nxt = r_state;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= X_ZERO;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      r_busy      <= (w_state_nxt != IDLE);
      r_result    <= w_res_nxt;
      r_illegal   <= w_ill_nxt;
    end
  end

  r_type_mdu_iter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .op    (w_op),
    .a     (rs1),
    .b     (rs2),
    .done  (w_iter_done),
    .res   (w_iter_res)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign illegal   = r_illegal;
  assign busy      = r_busy;

endmodule

// File: tb/tb_r_type_mdu.sv
// Self-checking bench for r_type_mdu: directed and random ops at XLEN=32
// against an arithmetic reference model, plus MULHU at XLEN=64.
module tb_r_type_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        in_ready, out_valid, illegal, busy;
  logic [31:0] result;

  logic        v64_in_valid, v64_out_ready;
  logic [6:0]  v64_funct7;
  logic [2:0]  v64_funct3;
  logic [63:0] v64_rs1, v64_rs2;
  logic        v64_in_ready, v64_out_valid, v64_illegal, v64_busy;
  logic [63:0] v64_result;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  r_type_mdu #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct7(funct7), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .illegal(illegal), .busy(busy)
  );

  r_type_mdu #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(v64_in_valid), .in_ready(v64_in_ready),
    .funct7(v64_funct7), .funct3(v64_funct3), .rs1(v64_rs1), .rs2(v64_rs2),
    .out_valid(v64_out_valid), .out_ready(v64_out_ready), .result(v64_result),
    .illegal(v64_illegal), .busy(v64_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V R-type semantics written with plain 64-bit arithmetic.
  function automatic logic [32:0] model(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    logic [31:0] r;
    logic        ill;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    ia = int'(a);
    ib = int'(b);
    r  = 32'd0;
    ill = 1'b0;
    if (f7 == 7'h00) begin
      case (f3)
        3'd0: r = a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = (ia < ib) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = a >> b[4:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else if (f7 == 7'h20 && f3 == 3'd0) begin
      r = a - b;
    end else if (f7 == 7'h20 && f3 == 3'd5) begin
      r = 32'(ia >>> b[4:0]);
    end else if (f7 == 7'h01) begin
      case (f3)
        3'd0: begin p = 64'(sa * sb); r = p[31:0];  end
        3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
        3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
        3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
        3'd4: r = (b == 32'd0) ? 32'hFFFFFFFF :
                  (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(ia / ib);
        3'd5: r = (b == 32'd0) ? 32'hFFFFFFFF : a / b;
        3'd6: r = (b == 32'd0) ? a :
                  (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'(ia % ib);
        default: r = (b == 32'd0) ? a : a % b;
      endcase
    end else begin
      ill = 1'b1;
    end
    return {ill, r};
  endfunction

  function automatic int exp_lat(input logic [6:0] f7, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b);
    if (f7 != 7'h01) return 1;
    if (f3 < 3'd4) return 33;
    if (b == 32'd0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [32:0] m;
    int el, lat;
    m  = model(f7, f3, a, b);
    el = exp_lat(f7, f3, a, b);
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    funct7 = f7; funct3 = f3; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    funct7 = 7'($urandom); funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(el));
    check({tag, ".result"}, 64'(result), 64'(m[31:0]));
    check({tag, ".illegal"}, 64'(illegal), 64'(m[32]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_result"}, 64'(result), 64'(m[31:0]));
      check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, ".hold_out_valid"}, 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".released"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] p128;
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    funct7 = 7'd0; funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
    v64_in_valid = 1'b0; v64_out_ready = 1'b0;
    v64_funct7 = 7'd0; v64_funct3 = 3'd0; v64_rs1 = 64'd0; v64_rs2 = 64'd0;
    repeat (2) @(negedge clk);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.result", 64'(result), 64'd0);
    check("rst.illegal", 64'(illegal), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    rst = 1'b0;

    run_op("add_ovf", 7'h00, 3'd0, 32'h7FFFFFFF, 32'd1, 0);
    run_op("sub",     7'h20, 3'd0, 32'd5, 32'd7, 0);
    run_op("sra",     7'h20, 3'd5, 32'h80000000, 32'd31, 0);
    run_op("mulh",    7'h01, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op("mulhu",   7'h01, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op("mul",     7'h01, 3'd0, 32'hFFFFFFFD, 32'd7, 0);
    run_op("div",     7'h01, 3'd4, 32'hFFFFFFF9, 32'd2, 0);
    run_op("rem",     7'h01, 3'd6, 32'hFFFFFFF9, 32'd2, 0);
    run_op("div_ovf", 7'h01, 3'd4, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op("divu_z",  7'h01, 3'd5, 32'h1234, 32'd0, 0);
    run_op("remu_z",  7'h01, 3'd7, 32'h1234, 32'd0, 0);
    run_op("div_bp",  7'h01, 3'd4, 32'd100, 32'd7, 5);
    run_op("ill",     7'h20, 3'd1, 32'd9, 32'd3, 0);

    // Reset in the middle of a divide.
    @(negedge clk);
    funct7 = 7'h01; funct3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid.busy", 64'(busy), 64'd1);
    check("mid.in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.out_valid", 64'(out_valid), 64'd0);
    check("abort.in_ready", 64'(in_ready), 64'd1);
    check("abort.busy", 64'(busy), 64'd0);
    run_op("add_after_rst", 7'h00, 3'd0, 32'd40, 32'd2, 0);

    for (int i = 0; i < 40; i++) begin
      logic [6:0] f7;
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      run_op("rand", f7, 3'($urandom), pick_val(), pick_val(), 0);
    end

    // XLEN=64 MULHU.
    for (int k = 0; k < 2; k++) begin
      logic [63:0] a64, b64;
      a64 = (k == 0) ? 64'hFFFFFFFFFFFFFFFF : {$urandom, $urandom};
      b64 = (k == 0) ? 64'hFFFFFFFFFFFFFFFF : {$urandom, $urandom};
      p128 = {64'd0, a64} * {64'd0, b64};
      @(negedge clk);
      v64_funct7 = 7'h01; v64_funct3 = 3'd3; v64_rs1 = a64; v64_rs2 = b64; v64_in_valid = 1'b1;
      @(negedge clk);
      v64_in_valid = 1'b0; v64_rs1 = 64'd0; v64_rs2 = 64'd0;
      lat = 1;
      while (!v64_out_valid && lat < 200) begin
        @(negedge clk);
        lat++;
      end
      check("x64.latency", 64'(lat), 64'd65);
      check("x64.mulhu", v64_result, p128[127:64]);
      check("x64.illegal", 64'(v64_illegal), 64'd0);
      v64_out_ready = 1'b1;
      @(negedge clk);
      v64_out_ready = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
